// File: rtl/dual_issue_ctrl_alu_pkg.sv
// Shared definitions for the dual-issue decode-to-execute slice:
// opcode and funct encodings, ALU-op classes, 4-bit ALU-control codes
// and the ID/EX control bundle.
package dual_issue_ctrl_alu_pkg;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU-control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpAnd   = 2'b11
    } aluop_e;

    // Control bundle held in the ID/EX register
    typedef struct packed {
        logic   regdst;
        logic   memread;
        logic   memwrite;
        aluop_e aluop;
        logic   regwrite;
        logic   regwrite1;
        logic   alusrc;
    } ctrl_t;

endpackage

// File: rtl/dual_issue_ctrl_alu_alu_core.sv
// ALU-control decode plus the W-bit ALU. Purely combinational.
// Ports:
//   aluop_i   ALU-op class from ID/EX
//   funct_i   R-type funct field from ID/EX
//   a_i, b_i  operands
//   aluctl_o  decoded 4-bit ALU control
//   result_o  ALU output
module dual_issue_ctrl_alu_alu_core
    import dual_issue_ctrl_alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  aluop_e         aluop_i,
    input  logic [5:0]     funct_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [3:0]     aluctl_o,
    output logic [W-1:0]   result_o
);

    always_comb begin
        aluctl_o = ALU_AND;
        case (aluop_i)
            AluOpAdd: aluctl_o = ALU_ADD;
            AluOpSub: aluctl_o = ALU_SUB;
            AluOpAnd: aluctl_o = ALU_AND;
            AluOpFunct: begin
                case (funct_i)
                    FN_ADD:  aluctl_o = ALU_ADD;
                    FN_SUB:  aluctl_o = ALU_SUB;
                    FN_AND:  aluctl_o = ALU_AND;
                    FN_OR:   aluctl_o = ALU_OR;
                    FN_XOR:  aluctl_o = ALU_XOR;
                    FN_NOR:  aluctl_o = ALU_NOR;
                    FN_SLT:  aluctl_o = ALU_SLT;
                    default: aluctl_o = ALU_AND;
                endcase
            end
            default: aluctl_o = ALU_AND;
        endcase
    end

    always_comb begin
        result_o = '0;
        case (aluctl_o)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = ($signed(a_i) < $signed(b_i)) ? W'(1) : '0;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/dual_issue_ctrl_alu_main_decoder.sv
// Main decoder for both issue slots. Purely combinational.
// Ports:
//   opcode_i    slot-0 opcode (R-type/ADDI/BEQ/BNE)
//   opcode1_i   slot-1 opcode (LW/SW)
//   ctrl_o      merged control bundle for the ID/EX register
//   branch_eq_o BEQ decoded
//   branch_ne_o BNE decoded
module dual_issue_ctrl_alu_main_decoder
    import dual_issue_ctrl_alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] opcode1_i,
    output ctrl_t      ctrl_o,
    output logic       branch_eq_o,
    output logic       branch_ne_o
);

    always_comb begin
        ctrl_o       = '0;
        ctrl_o.aluop = AluOpAdd;
        branch_eq_o  = 1'b0;
        branch_ne_o  = 1'b0;

        // Slot 0
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = AluOpFunct;
            end
            OP_ADDI: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
            end
            OP_BEQ: begin
                branch_eq_o  = 1'b1;
                ctrl_o.aluop = AluOpSub;
            end
            OP_BNE: begin
                branch_ne_o  = 1'b1;
                ctrl_o.aluop = AluOpSub;
            end
            default: ;
        endcase

        // Slot 1 decodes independently; both slots may assert together
        case (opcode1_i)
            OP_LW: begin
                ctrl_o.memread   = 1'b1;
                ctrl_o.regwrite1 = 1'b1;
            end
            OP_SW:   ctrl_o.memwrite = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/dual_issue_ctrl_alu.sv
// Decode-to-execute slice of the dual-issue five-stage core.
// Decodes both slots, resolves branches in ID, holds the ID/EX register,
// runs the ALU in EX and registers its result into EX/MEM.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   stall                inject a bubble into ID/EX control
//   flush                zero the EX/MEM result
//   opcode, opcode1      slot-0 / slot-1 opcodes
//   funct, rs_data, rt_data, seimm  slot-0 operand fields
//   branch_eq/ne, pcsrc  combinational branch decode and resolution
//   *_ex                 registered EX-stage control
//   aluctl_ex            combinational ALU control in EX
//   alu_result, alu_zero EX/MEM result and its zero flag
module dual_issue_ctrl_alu
    import dual_issue_ctrl_alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic [5:0]   opcode,
    input  logic [5:0]   opcode1,
    input  logic [5:0]   funct,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [W-1:0] seimm,
    output logic         branch_eq,
    output logic         branch_ne,
    output logic         pcsrc,
    output logic         regdst_ex,
    output logic         memread_ex,
    output logic         memwrite_ex,
    output logic         regwrite_ex,
    output logic         regwrite1_ex,
    output logic [3:0]   aluctl_ex,
    output logic [W-1:0] alu_result,
    output logic         alu_zero
);

    ctrl_t        ctrl_d;
    ctrl_t        ctrl_q;
    logic [W-1:0] rs_q, rt_q, seimm_q;
    logic [5:0]   funct_q;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic [W-1:0] result_d, result_q;
    logic         zero_q;

    dual_issue_ctrl_alu_main_decoder u_main_decoder (
        .opcode_i    (opcode),
        .opcode1_i   (opcode1),
        .ctrl_o      (ctrl_d),
        .branch_eq_o (branch_eq),
        .branch_ne_o (branch_ne)
    );

    assign pcsrc = (branch_eq & (rs_data == rt_data)) | (branch_ne & (rs_data != rt_data));

    // ID/EX: a stall bubbles only the control; operands always advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            seimm_q <= '0;
            funct_q <= '0;
        end else begin
            ctrl_q  <= stall ? '0 : ctrl_d;
            rs_q    <= rs_data;
            rt_q    <= rt_data;
            seimm_q <= seimm;
            funct_q <= funct;
        end
    end

    assign alu_b = ctrl_q.alusrc ? seimm_q : rt_q;

    dual_issue_ctrl_alu_alu_core #(
        .W (W)
    ) u_alu_core (
        .aluop_i  (ctrl_q.aluop),
        .funct_i  (funct_q),
        .a_i      (rs_q),
        .b_i      (alu_b),
        .aluctl_o (aluctl_ex),
        .result_o (alu_out)
    );

    assign result_d = flush ? '0 : alu_out;

    // EX/MEM: zero flag tracks the value actually captured (flushed or not)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= (result_d == '0);
        end
    end

    assign regdst_ex    = ctrl_q.regdst;
    assign memread_ex   = ctrl_q.memread;
    assign memwrite_ex  = ctrl_q.memwrite;
    assign regwrite_ex  = ctrl_q.regwrite;
    assign regwrite1_ex = ctrl_q.regwrite1;
    assign alu_result   = result_q;
    assign alu_zero     = zero_q;

endmodule

// File: tb/tb_dual_issue_ctrl_alu.sv
// Scoreboard bench for dual_issue_ctrl_alu. Each issue pushes its expected
// EX control (checked one edge later) and expected EX/MEM result (checked
// two edges later); branch outputs are checked in the issue cycle.
module tb_dual_issue_ctrl_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic [5:0]  opcode, opcode1, funct;
    logic [31:0] rs_data, rt_data, seimm;
    logic        branch_eq, branch_ne, pcsrc;
    logic        regdst_ex, memread_ex, memwrite_ex, regwrite_ex, regwrite1_ex;
    logic [3:0]  aluctl_ex;
    logic [31:0] alu_result;
    logic        alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_issue_ctrl_alu #(
        .W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .opcode       (opcode),
        .opcode1      (opcode1),
        .funct        (funct),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .seimm        (seimm),
        .branch_eq    (branch_eq),
        .branch_ne    (branch_ne),
        .pcsrc        (pcsrc),
        .regdst_ex    (regdst_ex),
        .memread_ex   (memread_ex),
        .memwrite_ex  (memwrite_ex),
        .regwrite_ex  (regwrite_ex),
        .regwrite1_ex (regwrite1_ex),
        .aluctl_ex    (aluctl_ex),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
    );

    typedef struct packed {
        logic       regdst;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       regwrite1;
        logic [3:0] aluctl;
    } exp_ctrl_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
    } exp_res_t;

    exp_ctrl_t ctrl_sb[$];
    exp_res_t  res_sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] m_aluctl(input logic [1:0] aluop, input logic [5:0] fn);
        case (aluop)
            2'b00: return 4'b0010;
            2'b01: return 4'b0110;
            2'b11: return 4'b0000;
            default: begin
                case (fn)
                    6'b100000: return 4'b0010;
                    6'b100010: return 4'b0110;
                    6'b100100: return 4'b0000;
                    6'b100101: return 4'b0001;
                    6'b100110: return 4'b1101;
                    6'b100111: return 4'b1100;
                    6'b101010: return 4'b0111;
                    default:   return 4'b0000;
                endcase
            end
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1101: return a ^ b;
            4'b1100: return ~(a | b);
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One issue cycle: check matured scoreboard entries, drive, check branch outputs, push.
    task automatic step(input logic [5:0] op, input logic [5:0] op1, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                        input logic st, input logic fl);
        exp_ctrl_t ec;
        exp_res_t  er;
        logic      beq, bne, alusrc;
        logic [1:0] aluop;
        @(negedge clk);
        if (ctrl_sb.size() > 0) begin
            ec = ctrl_sb.pop_front();
            check("regdst_ex", regdst_ex, ec.regdst);
            check("memread_ex", memread_ex, ec.memread);
            check("memwrite_ex", memwrite_ex, ec.memwrite);
            check("regwrite_ex", regwrite_ex, ec.regwrite);
            check("regwrite1_ex", regwrite1_ex, ec.regwrite1);
            check("aluctl_ex", aluctl_ex, ec.aluctl);
        end
        if (res_sb.size() >= 2) begin
            er = res_sb.pop_front();
            check("alu_result", alu_result, er.result);
            check("alu_zero", alu_zero, er.zero);
        end
        // Flush now hits the previous issue, which is in EX this cycle
        if (fl && res_sb.size() > 0) begin
            er = res_sb.pop_back();
            er.result = 32'd0;
            er.zero   = 1'b1;
            res_sb.push_back(er);
        end

        opcode = op; opcode1 = op1; funct = fn;
        rs_data = rs; rt_data = rt; seimm = imm;
        stall = st; flush = fl;

        ec = '0; beq = 1'b0; bne = 1'b0; alusrc = 1'b0; aluop = 2'b00;
        if (op == 6'b000000) begin ec.regdst = 1'b1; ec.regwrite = 1'b1; aluop = 2'b10; end
        if (op == 6'b001000) begin ec.regwrite = 1'b1; alusrc = 1'b1; end
        if (op == 6'b000100) begin beq = 1'b1; aluop = 2'b01; end
        if (op == 6'b000101) begin bne = 1'b1; aluop = 2'b01; end
        if (op1 == 6'b100011) begin ec.memread = 1'b1; ec.regwrite1 = 1'b1; end
        if (op1 == 6'b101011) ec.memwrite = 1'b1;

        #1;
        check("branch_eq", branch_eq, beq);
        check("branch_ne", branch_ne, bne);
        check("pcsrc", pcsrc, (beq && rs == rt) || (bne && rs != rt));

        if (st) begin
            ec = '0; aluop = 2'b00; alusrc = 1'b0;
        end
        ec.aluctl = m_aluctl(aluop, fn);
        er.result = m_alu(ec.aluctl, rs, alusrc ? imm : rt);
        er.zero   = (er.result == 32'd0);
        ctrl_sb.push_back(ec);
        res_sb.push_back(er);
    endtask

    localparam logic [5:0] NOP = 6'b111111;

    initial begin
        logic [5:0] fn_tab [8];
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                   6'b100110, 6'b100111, 6'b101010, 6'b110011};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        opcode = NOP; opcode1 = NOP; funct = '0;
        rs_data = '0; rt_data = '0; seimm = '0;
        #12;
        check("rst_alu_result", alu_result, 32'd0);
        check("rst_alu_zero", alu_zero, 1'b0);
        check("rst_regwrite_ex", regwrite_ex, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(6'b000000, NOP, 6'b100000, 32'd7, 32'd5, 32'd0, 1'b0, 1'b0);
        step(6'b000000, NOP, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        step(6'b001000, NOP, 6'b000000, 32'h10, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(6'b001000, NOP, 6'b000000, 32'hFFFF_FFFF, 32'd9, 32'd1, 1'b0, 1'b0);
        step(6'b000100, NOP, 6'b000000, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        step(6'b000101, NOP, 6'b000000, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        step(6'b000101, NOP, 6'b000000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step(6'b000000, 6'b100011, 6'b100100, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 1'b0);
        step(NOP, 6'b101011, 6'b000000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
        step(6'b000000, 6'b100011, 6'b100101, 32'd6, 32'd3, 32'd0, 1'b1, 1'b0);
        step(6'b000000, NOP, 6'b100010, 32'd9, 32'd4, 32'd0, 1'b0, 1'b0);
        step(NOP, NOP, 6'b000000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        // stall and flush together
        step(6'b000000, NOP, 6'b100110, 32'hAA, 32'h55, 32'd0, 1'b0, 1'b0);
        step(6'b000000, 6'b100011, 6'b100111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            step(6'b000000, NOP, fn_tab[$urandom_range(0, 7)], $urandom, $urandom,
                 $urandom, 1'b0, 1'b0);
        end

        // Mid-stream asynchronous reset with alu_result = 5 and live EX control
        step(6'b001000, NOP, 6'b000000, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        step(6'b000000, 6'b100011, 6'b100000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        step(NOP, NOP, 6'b000000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_alu_result", alu_result, 32'd0);
        check("async_rst_regdst_ex", regdst_ex, 1'b0);
        check("async_rst_regwrite_ex", regwrite_ex, 1'b0);
        check("async_rst_memread_ex", memread_ex, 1'b0);
        check("async_rst_regwrite1_ex", regwrite1_ex, 1'b0);
        ctrl_sb.delete();
        res_sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        step(6'b000000, 6'b101011, 6'b100010, 32'd20, 32'd8, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(NOP, NOP, 6'b000000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
